// File: rtl/mc_sequencer_pkg.sv
// Shared definitions for the multicycle ARM-style control sequencer:
// FSM state encoding, ALUControl codes, condition codes, Op field values.
// The FPU states exist only when FPU_SEQ_EN is defined.
package mc_sequencer_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_EXECM,
        S_MULWB,
`ifdef FPU_SEQ_EN
        S_FPUEX,
        S_FPUWB,
`endif
        S_UNKNOWN
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_ORR   = 3'b011,
        ALU_MUL   = 3'b100,
        ALU_UMULL = 3'b101
    } alu_ctrl_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    // Op field Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_FP  = 2'b11;

    // Data-processing cmd field Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] REG_PC = 4'b1111;

endpackage

// File: rtl/mc_sequencer_cond_unit.sv
// cond_unit: stored {N,Z,C,V} flag register plus condition evaluation.
// Flags clear asynchronously on reset; updates happen only when the
// instruction's own condition passes against the currently stored flags.
module cond_unit
    import mc_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    // Evaluate the condition field against the stored flags
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;  // NV: never executes
        endcase
    end

    // Flag register: N,Z on flag_w[1], C,V on flag_w[0], both gated by cond_ex
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multicycle control FSM for an ARM-style datapath.
// Outputs are decoded combinationally from the current state and forced
// to zero while reset is high. Define FPU_SEQ_EN to add the FPUEX/FPUWB
// path for Op=11; otherwise Op=11 goes through UNKNOWN.
module mc_sequencer
    import mc_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl,
    output logic        RegSrc64b,
    output logic        FPUWrite
);

    state_t     state, next_state;
    logic [1:0] op;
    logic       cond_ex;
    logic [2:0] alu_dec;
    logic       alu_valid;
    logic       alu_addsub;
    logic       next_pc, branch, reg_w, mem_w, ir_w, adr_src, m64;
    logic [1:0] src_a, src_b, res_src, flag_w;
    logic [2:0] alu_ctl;
`ifdef FPU_SEQ_EN
    logic       fpu_w;
`endif
    logic       unused_instr;

    assign op           = Instr[27:26];
    assign unused_instr = &{1'b0, Instr[19:16], Instr[11:8], Instr[3:0]};

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Instr[31:28]),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .cond_ex   (cond_ex)
    );

    // Data-processing cmd decode; unsupported cmds give ADD with no write-back
    always_comb begin
        alu_dec   = ALU_ADD;
        alu_valid = 1'b1;
        case (Instr[24:21])
            CMD_ADD: alu_dec = ALU_ADD;
            CMD_SUB: alu_dec = ALU_SUB;
            CMD_AND: alu_dec = ALU_AND;
            CMD_ORR: alu_dec = ALU_ORR;
            default: alu_valid = 1'b0;
        endcase
        alu_addsub = alu_valid && (alu_dec == ALU_ADD || alu_dec == ALU_SUB);
    end

    // Per-state control decode and next-state selection
    always_comb begin
        next_state = S_FETCH;
        next_pc    = 1'b0;
        branch     = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        adr_src    = 1'b0;
        m64        = 1'b0;
        src_a      = 2'b00;
        src_b      = 2'b00;
        res_src    = 2'b00;
        flag_w     = 2'b00;
        alu_ctl    = ALU_ADD;
`ifdef FPU_SEQ_EN
        fpu_w      = 1'b0;
`endif
        case (state)
            S_FETCH: begin
                ir_w       = 1'b1;
                next_pc    = 1'b1;
                src_a      = 2'b01;
                src_b      = 2'b10;
                res_src    = 2'b10;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                src_a   = 2'b01;
                src_b   = 2'b10;
                res_src = 2'b10;
                case (op)
                    OP_MEM: next_state = S_MEMADR;
                    OP_BR:  next_state = S_BRANCH;
                    OP_DP: begin
                        if (!Instr[25] && Instr[7:4] == 4'b1001) next_state = S_EXECM;
                        else if (Instr[25])                      next_state = S_EXECI;
                        else                                     next_state = S_EXECR;
                    end
`ifdef FPU_SEQ_EN
                    default: next_state = S_FPUEX;
`else
                    default: next_state = S_UNKNOWN;
`endif
                endcase
            end
            S_MEMADR: begin
                src_b      = 2'b01;
                next_state = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                res_src = 2'b01;
                reg_w   = 1'b1;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                src_b      = (state == S_EXECI) ? 2'b01 : 2'b00;
                alu_ctl    = alu_dec;
                flag_w     = {Instr[20], Instr[20] & alu_addsub};
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w = alu_valid;
            end
            S_BRANCH: begin
                src_b   = 2'b01;
                res_src = 2'b10;
                branch  = 1'b1;
            end
            S_EXECM: begin
                m64        = 1'b1;
                alu_ctl    = Instr[23] ? ALU_UMULL : ALU_MUL;
                flag_w     = {Instr[20], 1'b0};
                next_state = S_MULWB;
            end
            S_MULWB: begin
                m64   = 1'b1;
                reg_w = 1'b1;
            end
`ifdef FPU_SEQ_EN
            S_FPUEX: begin
                next_state = S_FPUWB;
            end
            S_FPUWB: begin
                fpu_w = 1'b1;
            end
`endif
            default: next_state = S_FETCH;  // UNKNOWN: no writes
        endcase
    end

    // State register; reset returns to FETCH at once, even mid-instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    // Output gating: condition-qualified writes, all zeros while in reset
    always_comb begin
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        RegSrc     = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        RegSrc64b  = 1'b0;
        FPUWrite   = 1'b0;
        if (!reset) begin
            PCWrite    = next_pc | ((branch | (reg_w & (Instr[15:12] == REG_PC))) & cond_ex);
            MemWrite   = mem_w & cond_ex;
            RegWrite   = reg_w & cond_ex;
            IRWrite    = ir_w;
            AdrSrc     = adr_src;
            RegSrc     = {(op == OP_MEM) & ~Instr[20], (op == OP_BR)};
            ALUSrcA    = src_a;
            ALUSrcB    = src_b;
            ResultSrc  = res_src;
            ImmSrc     = op;
            ALUControl = alu_ctl;
            RegSrc64b  = m64;
`ifdef FPU_SEQ_EN
            FPUWrite   = fpu_w & cond_ex;
`endif
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Testbench for mc_sequencer: directed instruction table, hand-written
// reset-in-flight sequence, and random instructions against a per-
// instruction reference model of the control outputs.
module tb_mc_sequencer;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       ir_write;
        logic       adr_src;
        logic [1:0] reg_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic       reg_src64b;
        logic       fpu_write;
    } out_t;

    typedef struct {
        logic [31:0] ins;
        logic [3:0]  af;
        int          len;
        logic [7:0]  rw, mw, pw, adr, m64, fpu;
        logic [2:0]  alu2;   // ALUControl in the third cycle
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc64b, FPUWrite;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    out_t        dut_out;

    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] model_flags = 4'h0;
    out_t exp_q[$];
    vec_t vecs[14];

    always #5 clk = ~clk;

    mc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (instr),
        .ALUFlags   (alu_flags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .RegSrc64b  (RegSrc64b),
        .FPUWrite   (FPUWrite)
    );

    assign dut_out = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ImmSrc, ALUControl, RegSrc64b, FPUWrite};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ARM condition table over {N,Z,C,V}; NV never passes
    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'ha: return n == v;
            4'hb: return n != v;
            4'hc: return !z && (n == v);
            4'hd: return z || (n != v);
            4'he: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected per-cycle outputs of one instruction; updates model_flags
    task automatic build_expect(input logic [31:0] ins, input logic [3:0] af);
        out_t       base, o;
        logic [1:0] op;
        logic       s, rd_pc, ce, valid;
        logic [2:0] ac;
        op    = ins[27:26];
        s     = ins[20];
        rd_pc = (ins[15:12] == 4'hf);
        ce    = cond_holds(ins[31:28], model_flags);
        base  = '0;
        base.imm_src = op;
        base.reg_src = {(op == 2'b01) && !s, op == 2'b10};
        exp_q.delete();
        o = base;
        o.ir_write = 1'b1; o.pc_write = 1'b1;
        o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.result_src = 2'b10;
        exp_q.push_back(o);                         // fetch
        o.ir_write = 1'b0; o.pc_write = 1'b0;
        exp_q.push_back(o);                         // decode
        case (op)
            2'b01: begin
                o = base; o.alu_src_b = 2'b01;
                exp_q.push_back(o);                 // address
                o = base; o.adr_src = 1'b1;
                if (s) begin
                    exp_q.push_back(o);             // read
                    o = base; o.result_src = 2'b01;
                    o.reg_write = ce; o.pc_write = ce && rd_pc;
                    exp_q.push_back(o);             // load write-back
                end else begin
                    o.mem_write = ce;
                    exp_q.push_back(o);             // store
                end
            end
            2'b10: begin
                o = base; o.alu_src_b = 2'b01; o.result_src = 2'b10; o.pc_write = ce;
                exp_q.push_back(o);
            end
            2'b00: begin
                if (!ins[25] && ins[7:4] == 4'b1001) begin
                    o = base; o.reg_src64b = 1'b1; o.alu_control = ins[23] ? 3'd5 : 3'd4;
                    exp_q.push_back(o);
                    if (ce && s) model_flags[3:2] = af[3:2];
                    ce = cond_holds(ins[31:28], model_flags);
                    o = base; o.reg_src64b = 1'b1; o.reg_write = ce; o.pc_write = ce && rd_pc;
                    exp_q.push_back(o);
                end else begin
                    valid = 1'b1;
                    case (ins[24:21])
                        4'b0100: ac = 3'd0;
                        4'b0010: ac = 3'd1;
                        4'b0000: ac = 3'd2;
                        4'b1100: ac = 3'd3;
                        default: begin ac = 3'd0; valid = 1'b0; end
                    endcase
                    o = base; o.alu_src_b = ins[25] ? 2'b01 : 2'b00; o.alu_control = ac;
                    exp_q.push_back(o);
                    if (ce && s) begin
                        model_flags[3:2] = af[3:2];
                        if (valid && ac <= 3'd1) model_flags[1:0] = af[1:0];
                    end
                    ce = cond_holds(ins[31:28], model_flags);
                    o = base; o.reg_write = valid && ce; o.pc_write = valid && ce && rd_pc;
                    exp_q.push_back(o);
                end
            end
            default: begin
                exp_q.push_back(base);
`ifdef FPU_SEQ_EN
                o = base; o.fpu_write = ce;
                exp_q.push_back(o);
`endif
            end
        endcase
    endtask

    task automatic run_instr(input string tag, input logic [31:0] ins, input logic [3:0] af);
        build_expect(ins, af);
        instr     = ins;
        alu_flags = af;
        for (int k = 0; k < exp_q.size(); k++) begin
            #1;
            check($sformatf("%s_c%0d", tag, k), 32'(dut_out), 32'(exp_q[k]));
            @(posedge clk); #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs_zero", 32'(dut_out), 32'h0);
        @(posedge clk); #1;
        reset       = 1'b0;
        model_flags = 4'h0;
    endtask

    initial begin
        logic [7:0]  rw, mw, pw, adr, m64, fpu;
        logic [2:0]  alu2;
        logic [31:0] ins;

        //              ins           af    len rw     mw     pc     adr    m64    fpu    alu@2
        vecs[0]  = '{32'hE0821003, 4'h0, 4, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0}; // ADD
        vecs[1]  = '{32'hE5910004, 4'h0, 5, 8'h10, 8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 3'd0}; // LDR
        vecs[2]  = '{32'hE5810004, 4'h0, 4, 8'h00, 8'h08, 8'h01, 8'h08, 8'h00, 8'h00, 3'd0}; // STR
        vecs[3]  = '{32'hE0500000, 4'h4, 4, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd1}; // SUBS Z=1
        vecs[4]  = '{32'h0A000000, 4'h0, 3, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 3'd0}; // BEQ taken
        vecs[5]  = '{32'h1A000000, 4'h0, 3, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0}; // BNE not
        vecs[6]  = '{32'h10821003, 4'h0, 4, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0}; // ADDNE
        vecs[7]  = '{32'hE3810001, 4'h0, 4, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd3}; // ORR imm
        vecs[8]  = '{32'hE0000291, 4'h0, 4, 8'h08, 8'h00, 8'h01, 8'h00, 8'h0C, 8'h00, 3'd4}; // MUL
        vecs[9]  = '{32'hE0810392, 4'h0, 4, 8'h08, 8'h00, 8'h01, 8'h00, 8'h0C, 8'h00, 3'd5}; // UMULL
        vecs[10] = '{32'hE082F003, 4'h0, 4, 8'h08, 8'h00, 8'h09, 8'h00, 8'h00, 8'h00, 3'd0}; // ADD pc
        vecs[11] = '{32'hE0221003, 4'h0, 4, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0}; // EOR unsup
        vecs[12] = '{32'hE3821001, 4'hF, 4, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd3}; // ORR, S=0
`ifdef FPU_SEQ_EN
        vecs[13] = '{32'hEE000000, 4'h0, 4, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h08, 3'd0}; // FP
`else
        vecs[13] = '{32'hEE000000, 4'h0, 3, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 3'd0}; // FP
`endif

        reset     = 1'b1;
        instr     = 32'h0;
        alu_flags = 4'h0;
        #2;
        check("reset_async_outputs", 32'(dut_out), 32'h0);
        apply_reset();

        // Directed table: per-cycle write masks plus return to FETCH
        foreach (vecs[i]) begin
            instr = vecs[i].ins; alu_flags = vecs[i].af;
            rw = '0; mw = '0; pw = '0; adr = '0; m64 = '0; fpu = '0; alu2 = '0;
            for (int k = 0; k < vecs[i].len; k++) begin
                #1;
                rw[k] = RegWrite; mw[k] = MemWrite; pw[k] = PCWrite;
                adr[k] = AdrSrc; m64[k] = RegSrc64b; fpu[k] = FPUWrite;
                if (k == 2) alu2 = ALUControl;
                @(posedge clk); #1;
            end
            check($sformatf("vec%0d_regwrite", i), 32'(rw),   32'(vecs[i].rw));
            check($sformatf("vec%0d_memwrite", i), 32'(mw),   32'(vecs[i].mw));
            check($sformatf("vec%0d_pcwrite", i),  32'(pw),   32'(vecs[i].pw));
            check($sformatf("vec%0d_adrsrc", i),   32'(adr),  32'(vecs[i].adr));
            check($sformatf("vec%0d_m64", i),      32'(m64),  32'(vecs[i].m64));
            check($sformatf("vec%0d_fpuwrite", i), 32'(fpu),  32'(vecs[i].fpu));
            check($sformatf("vec%0d_alu", i),      32'(alu2), 32'(vecs[i].alu2));
            check($sformatf("vec%0d_back_to_fetch", i), 32'(IRWrite), 32'h1);
        end

        // Reset in the middle of a store: write must vanish at once, flags clear
        apply_reset();
        run_instr("pre_subs", 32'hE0500000, 4'h4);      // sets Z
        instr = 32'hE5810004;
        repeat (3) @(posedge clk);
        #1;
        check("memwr_before_reset", 32'(MemWrite), 32'h1);
        #1 reset = 1'b1;
        #1;
        check("memwr_drops_async", 32'(MemWrite), 32'h0);
        check("outputs_zero_in_reset", 32'(dut_out), 32'h0);
        @(posedge clk); #1;
        reset       = 1'b0;
        model_flags = 4'h0;
        #1;
        check("fetch_after_reset", 32'(IRWrite), 32'h1);
        run_instr("beq_after_reset", 32'h0A000000, 4'h0); // Z cleared, not taken

        // Random instructions against the reference model
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 3))
                    0: ins[24:21] = 4'b0100;
                    1: ins[24:21] = 4'b0010;
                    2: ins[24:21] = 4'b0000;
                    default: ins[24:21] = 4'b1100;
                endcase
            end
            if ($urandom_range(0, 3) == 0) ins[7:4] = 4'b1001;
            run_instr($sformatf("rand%0d", i), ins, 4'($urandom_range(0, 15)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 Instr  in  32  registered instruction from the datapath IR.
REQ-004 ALUFlags  in  4  {N,Z,C,V} from the datapath ALU.
REQ-005 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc  out  1 each  datapath enables and selects.
REQ-006 RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  out  2 each  datapath mux selects.
REQ-007 ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 UMULL.
REQ-008 RegSrc64b, FPUWrite  out  1 each  multiply register-field select; FP register-file write enable.

Function
REQ-009 States SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, EXECM, MULWB, FPUEX, FPUWB, UNKNOWN.
REQ-010 FETCH SHALL assert IRWrite=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUControl=000 and NextPC, then go to DECODE.
REQ-011 DECODE SHALL drive ALUSrcA=01, ALUSrcB=10, ResultSrc=10 and dispatch by Op=Instr[27:26] as follows:
 - 01 -> MEMADR
 - 10 -> BRANCH
 - 00 with Instr[25]=0 and Instr[7:4]=1001 -> EXECM
 - 00 with Instr[25]=1 -> EXECI
 - 00 otherwise -> EXECR
 - 11 -> FPUEX
REQ-012 MEMADR SHALL drive ALUSrcA=00, ALUSrcB=01, ALUControl=000, then go to MEMRD if Instr[20]=1, else MEMWR.
REQ-013 MEMRD SHALL drive AdrSrc=1, ResultSrc=00 and go to MEMWB; MEMWB SHALL drive ResultSrc=01 with RegW and go to FETCH.
REQ-014 MEMWR SHALL drive AdrSrc=1, ResultSrc=00 with MemW and go to FETCH.
REQ-015 EXECR SHALL drive ALUSrcB=00; EXECI SHALL drive ALUSrcB=01; both SHALL use ALUSrcA=00 and decoded ALUControl, then go to ALUWB.
REQ-016 ALUWB SHALL drive ResultSrc=00 with RegW and go to FETCH.
REQ-017 BRANCH SHALL drive ALUSrcA=00, ALUSrcB=01, ALUControl=000, ResultSrc=10 with Branch, then go to FETCH.
REQ-018 EXECM SHALL drive RegSrc64b=1 and ALUControl=101 if Instr[23]=1, else 100, then go to MULWB; MULWB SHALL keep RegSrc64b=1, drive ResultSrc=00 with RegW, and go to FETCH.
REQ-019 FPUEX SHALL drive no writes and go to FPUWB; FPUWB SHALL assert FPUWrite gated by CondEx, then go to FETCH.
REQ-020 UNKNOWN SHALL drive all enables 0 and go to FETCH.
REQ-021 ALU decode SHALL map Instr[24:21] as 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other value SHALL yield ALUControl=000 and no RegW.
REQ-022 Flag-register updates SHALL work as follows:
 - FlagW[1]=Instr[20] SHALL update N,Z.
 - FlagW[0]=Instr[20] with ADD/SUB SHALL update C,V.
 - Updates SHALL occur only on the EXECR/EXECI/EXECM clock edge, gated by CondEx.
REQ-023 CondEx SHALL be evaluated from Instr[31:28] against the stored flags, per the ARM EQ..LE table; AL (1110) SHALL always be true.
REQ-024 Write gating SHALL be:
 - PCWrite = NextPC | ((Branch | (RegW & Instr[15:12]==1111)) & CondEx)
 - RegWrite = RegW & CondEx
 - MemWrite = MemW & CondEx
REQ-025 RegSrc[0] SHALL be 1 for Op=10; RegSrc[1] SHALL be 1 for Op=01 with Instr[20]=0; ImmSrc SHALL equal Op.
REQ-026 All outputs SHALL be decoded combinationally from the current state, and the next state SHALL be registered.

Reset
REQ-027 Reset SHALL force state FETCH and flags 0000 immediately, even mid-instruction; no pending write SHALL complete.
REQ-028 While reset is asserted, all enables SHALL be 0 and all selects SHALL be 00/000.

Configuration
REQ-029 FPU_SEQ_EN, default undefined, enables FP sequencing: when defined, Op=11 SHALL go to FPUEX; when undefined, Op=11 SHALL go to UNKNOWN, FPUWrite SHALL be tied 0, and the FPU states SHALL be absent.

Structure
REQ-030 A shared package SHALL hold the state enum, the ALUControl encodings, the condition-code encodings and the Op constants.
REQ-031 Condition evaluation plus the flag register SHALL be one sub-module, cond_unit.

Verification
REQ-032 ADD R1,R2,R3 (AL) -> FETCH,DECODE,EXECR,ALUWB in 4 cycles; RegWrite=1 only in ALUWB; ALUControl=000.
REQ-033 LDR -> 5 cycles, MEMRD AdrSrc=1, MEMWB ResultSrc=01 RegWrite=1; STR -> MemWrite=1 in MEMWR only.
REQ-034 SUBS with ALUFlags=0100, then BEQ -> flags Z=1; BRANCH PCWrite=1; BNE next instead -> PCWrite=0 in BRANCH.
REQ-035 UMULL (Instr[23]=1, [7:4]=1001) -> EXECM ALUControl=101, RegSrc64b=1 for 2 cycles, RegWrite=1 in MULWB.
REQ-036 Reset asserted during MEMWR -> MemWrite drops asynchronously; state FETCH on release; flags=0000.
REQ-037 Op=11 -> FPUWrite=1 in cycle 4 with FPU_SEQ_EN defined; without it, UNKNOWN then FETCH with FPUWrite=0.
